stopwatch_ctrl: RTL
===================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter: PRESCALE, default 4, clock cycles per count tick (legal range 2..65535).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rstn  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  command pulse: begin or resume counting.
REQ-005 stop  input  1  command pulse: pause counting.
REQ-006 clear  input  1  command pulse: return to IDLE and zero the count.
REQ-007 limit  input  12  BCD target (3 digits: [11:8] hundreds, [7:4] tens, [3:0] units).
REQ-008 count  output  12  registered BCD count, 000..999.
REQ-009 running  output  1  high while state is RUN.
REQ-010 done  output  1  one-cycle pulse when count reaches limit.
REQ-011 state  output  2  encoding: IDLE=0, RUN=1, PAUSE=2, DONE=3.

Function
REQ-012 Commands are sampled every cycle; priority is clear > stop > start.
REQ-013 A clear in any state shall set count=000, zero the prescaler, deassert done, and enter IDLE the next cycle.
REQ-014 In IDLE, start shall zero the prescaler and enter RUN; running goes high the next cycle.
REQ-015 In RUN, the prescaler shall increment every cycle, and a tick shall occur on the cycle it equals PRESCALE-1, when it wraps to 0.
REQ-016 The first tick after start from IDLE shall occur exactly PRESCALE cycles after the start cycle.
REQ-017 On a tick, count shall increment as a 3-digit BCD cascade: each digit wraps 9->0 and carries into the next digit; 999 wraps to 000 and counting continues.
REQ-018 When a tick updates count to a value equal to limit, the block shall enter DONE, and done shall be high in the same cycle count first shows limit.
REQ-019 In RUN, stop shall enter PAUSE; if stop coincides with a tick, the tick is suppressed (no increment).
REQ-020 In PAUSE, count and prescaler shall hold; start shall re-enter RUN with the prescaler resuming from its held value.
REQ-021 start while count equals limit (in IDLE or PAUSE) shall enter DONE directly and pulse done once, without counting.
REQ-022 In DONE, count shall hold and start and stop shall be ignored; only clear exits.
REQ-023 stop in IDLE or DONE, and start in RUN, shall be ignored.
REQ-024 A limit containing any digit above 9 shall never match; the count then wraps at 999 indefinitely.
REQ-025 limit is sampled live each cycle, and a change takes effect on the next tick compare.

Reset
REQ-026 While rstn=0: state=IDLE, count=000, prescaler=0, running=0, done=0, all asynchronously.
REQ-027 Deassertion of rstn shall be synchronous to clk; the first command is accepted on the first rising edge after rstn goes high.
REQ-028 Reset asserted mid-RUN shall abort immediately, with no done pulse.

Structure
REQ-029 A shared package stopwatch_pkg shall hold the state enum, BCD_W=4, NUM_DIGITS=3, and DIGIT_MAX=9.
REQ-030 A sub-module bcd_digit shall provide one digit with ports clk, rstn, en, clr, q[3:0], and a combinational carry (en && q==9); stopwatch_ctrl instantiates three in cascade.
REQ-031 FSM next-state logic and the prescaler shall live in stopwatch_ctrl; all outputs shall be registered.

Verification (PRESCALE=4)
REQ-032 Reset then start with limit=005 -> running=1 next cycle, count=001 after 4 cycles, count=005 with done=1 after 20 cycles, state=DONE.
REQ-033 Run with limit=FFF for 1000 ticks -> count passes 009->010, 099->100, 999->000, and done never asserts.
REQ-034 In RUN, stop in the same cycle as a tick -> no increment, state=PAUSE; after start, the next tick arrives after the remaining prescaler cycles.
REQ-035 start, stop, and clear all asserted in one cycle during RUN -> count=000, state=IDLE, done=0.
REQ-036 limit=000, start from IDLE -> state=DONE and a single done pulse; a further start is ignored.
REQ-037 rstn pulsed low mid-RUN at count=042 -> all outputs zero immediately; after rstn returns high, the FSM stays in IDLE until the next start.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch controller.
// Holds the FSM state encoding, digit geometry and a BCD increment helper.
package stopwatch_pkg;

    localparam int BCD_W      = 4;
    localparam int NUM_DIGITS = 3;
    localparam int DIGIT_MAX  = 9;
    localparam int CNT_W      = BCD_W * NUM_DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Value the digit cascade will hold after one tick; lets the FSM
    // compare against limit in the same cycle the count updates.
    function automatic logic [CNT_W-1:0] bcd_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        logic             c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (c) begin
                if (r[i*BCD_W +: BCD_W] == BCD_W'(DIGIT_MAX)) begin
                    r[i*BCD_W +: BCD_W] = '0;
                end else begin
                    r[i*BCD_W +: BCD_W] = r[i*BCD_W +: BCD_W] + 1'b1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of the stopwatch count: increments on en, wraps 9->0,
// and raises a combinational carry for the next digit up.
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       en,
    input  logic       clr,
    output logic [3:0] q,
    output logic       carry
);

    assign carry = en && (q == BCD_W'(DIGIT_MAX));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= carry ? '0 : q + 1'b1;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Three-digit BCD stopwatch: prescaled tick, start/stop/clear FSM, and a
// one-cycle done pulse when the count reaches a live BCD limit.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int PRESCALE = 4
)(
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    input  logic [11:0] limit,
    output logic [11:0] count,
    output logic        running,
    output logic        done,
    output logic [1:0]  state
);

    localparam int             PS_W    = $clog2(PRESCALE);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    state_t          st;
    logic [PS_W-1:0] presc;
    logic            tick;
    logic            hit;
    logic            at_limit;
    logic            c0, c1;
    logic            unused_wrap;

    // A stop or clear in the tick cycle suppresses the increment.
    assign tick     = (st == RUN) && !clear && !stop && (presc == PS_LAST);
    // A limit digit above 9 can never equal a BCD count, so it never matches.
    assign hit      = (bcd_inc(count) == limit);
    assign at_limit = (count == limit);
    assign state    = st;

    bcd_digit u_units (
        .clk(clk), .rstn(rstn), .en(tick), .clr(clear),
        .q(count[3:0]), .carry(c0)
    );
    bcd_digit u_tens (
        .clk(clk), .rstn(rstn), .en(c0), .clr(clear),
        .q(count[7:4]), .carry(c1)
    );
    bcd_digit u_hundreds (
        .clk(clk), .rstn(rstn), .en(c1), .clr(clear),
        .q(count[11:8]), .carry(unused_wrap)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st      <= IDLE;
            presc   <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clear) begin
                st      <= IDLE;
                presc   <= '0;
                running <= 1'b0;
            end else begin
                case (st)
                    IDLE: begin
                        if (start && !stop) begin
                            presc <= '0;
                            if (at_limit) begin
                                st   <= DONE;
                                done <= 1'b1;
                            end else begin
                                st      <= RUN;
                                running <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (stop) begin
                            st      <= PAUSE;
                            running <= 1'b0;
                        end else if (presc == PS_LAST) begin
                            presc <= '0;
                            if (hit) begin
                                st      <= DONE;
                                running <= 1'b0;
                                done    <= 1'b1;
                            end
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
                    PAUSE: begin
                        // Prescaler is left untouched so the period resumes.
                        if (start && !stop) begin
                            if (at_limit) begin
                                st   <= DONE;
                                done <= 1'b1;
                            end else begin
                                st      <= RUN;
                                running <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                    end
                    default: begin
                        st      <= IDLE;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
